// File: rtl/parity_rx_pkg.sv
// -----------------------------------------------------------------------------
// parity_rx_pkg
// Shared definitions for the serial parity receiver: frame geometry, the
// receiver state encoding and a small helper that classifies states.
// -----------------------------------------------------------------------------
package parity_rx_pkg;

    // Sampled bits per frame: start + 8 data + parity + stop.
    localparam int unsigned FRAME_BITS = 11;
    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned CNT_W      = 3;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DATA      = 3'd1,
        PARITY    = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } rx_state_e;

    // Any state other than IDLE means a frame (or a line break) is in progress.
    function automatic logic state_is_busy(input rx_state_e s);
        return (s != IDLE);
    endfunction

endpackage : parity_rx_pkg

// File: rtl/parity_calc8.sv
// -----------------------------------------------------------------------------
// parity_calc8
// Purely combinational parity checker for one received byte.
//   data_i     : 8 received data bits
//   parity_i   : received parity bit
//   odd_i      : 0 = even parity expected, 1 = odd parity expected
//   mismatch_o : 1 when the received parity does not match the expected sense
// -----------------------------------------------------------------------------
module parity_calc8
    import parity_rx_pkg::*;
(
    input  logic [DATA_BITS-1:0] data_i,
    input  logic                 parity_i,
    input  logic                 odd_i,
    output logic                 mismatch_o
);

    // Even parity: total ones across data+parity must be even; odd flips that.
    always_comb begin
        mismatch_o = (^data_i) ^ parity_i ^ odd_i;
    end

endmodule : parity_calc8

// File: rtl/serial_parity_rx.sv
// -----------------------------------------------------------------------------
// serial_parity_rx
// Receives 11-bit serial frames (start 0, d0..d7 LSB first, parity, stop 1),
// sampling the line only on cycles where bitEn is high, and presents the
// received byte with a level-style valid/ack handshake.
//   clk       : clock, all state changes on the rising edge
//   rst       : synchronous active-high reset
//   sin       : serial line, idle high
//   bitEn     : bit strobe, sin is sampled only when high
//   ack       : consumer acknowledges the held byte
//   dataOut   : last received byte
//   dataValid : high while an unacknowledged byte is held
//   parityErr : parity status of the held byte
//   frameErr  : one-cycle pulse on a bad stop bit
//   overrun   : sticky, an unacknowledged byte was overwritten
//   busy      : receiver is not in IDLE
// -----------------------------------------------------------------------------
module serial_parity_rx
    import parity_rx_pkg::*;
#(
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sin,
    input  logic                 bitEn,
    input  logic                 ack,
    output logic [DATA_BITS-1:0] dataOut,
    output logic                 dataValid,
    output logic                 parityErr,
    output logic                 frameErr,
    output logic                 overrun,
    output logic                 busy
);

    rx_state_e            state_q,   state_d;
    logic [CNT_W-1:0]     cnt_q,     cnt_d;
    logic [DATA_BITS-1:0] shift_q,   shift_d;
    logic                 par_bit_q, par_bit_d;
    logic [DATA_BITS-1:0] data_q,    data_d;
    logic                 valid_q,   valid_d;
    logic                 perr_q,    perr_d;
    logic                 ferr_q,    ferr_d;
    logic                 ovr_q,     ovr_d;
    logic                 complete_s;
    logic                 mismatch_s;

    // Parity of the assembled byte; shift_q and par_bit_q are stable by STOP.
    parity_calc8 u_parity (
        .data_i     (shift_q),
        .parity_i   (par_bit_q),
        .odd_i      (ODD_PARITY),
        .mismatch_o (mismatch_s)
    );

    // Frame FSM next-state: advances only on strobed cycles.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        par_bit_d  = par_bit_q;
        ferr_d     = 1'b0;
        complete_s = 1'b0;
        if (bitEn) begin
            case (state_q)
                IDLE: begin
                    if (!sin) begin
                        state_d = DATA;
                        cnt_d   = 3'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end
                DATA: begin
                    shift_d[cnt_q] = sin;
                    if (cnt_q == 3'd7) begin
                        state_d = PARITY;
                        cnt_d   = 3'd0;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                PARITY: begin
                    par_bit_d = sin;
                    state_d   = STOP;
                end
                STOP: begin
                    if (sin) begin
                        complete_s = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        // Bad stop: drop the byte and wait out the low line.
                        ferr_d  = 1'b1;
                        state_d = WAIT_HIGH;
                    end
                end
                WAIT_HIGH: begin
                    if (sin) begin
                        state_d = IDLE;
                    end else begin
                        state_d = WAIT_HIGH;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = 3'd0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Output holding register: load on completion, release on ack.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        perr_d  = perr_q;
        ovr_d   = ovr_q;
        if (complete_s) begin
            data_d  = shift_q;
            perr_d  = mismatch_s;
            valid_d = 1'b1;
            // A same-cycle ack consumes the old byte, so nothing is lost.
            if (valid_q && !ack) begin
                ovr_d = 1'b1;
            end else if (valid_q && ack) begin
                ovr_d = 1'b0;
            end else begin
                ovr_d = ovr_q;
            end
        end else if (valid_q && ack) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 3'd0;
            shift_q   <= 8'h00;
            par_bit_q <= 1'b0;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            par_bit_q <= par_bit_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

    assign dataOut   = data_q;
    assign dataValid = valid_q;
    assign parityErr = perr_q;
    assign frameErr  = ferr_q;
    assign overrun   = ovr_q;
    assign busy      = state_is_busy(state_q);

endmodule : serial_parity_rx

// File: tb/tb_serial_parity_rx.sv
module tb_serial_parity_rx;

    logic       clk = 1'b0;
    logic       rst, sin, bitEn, ack;
    logic [7:0] dout_e, dout_o;
    logic       dv_e, dv_o, pe_e, pe_o, fe_e, fe_o, ov_e, ov_o, busy_e, busy_o;

    int checks = 0;
    int errors = 0;

    // Reference model of what the consumer should see.
    logic [7:0] m_data;
    logic       m_valid, m_perr_even, m_perr_odd, m_ovr;

    always #5 clk = ~clk;

    serial_parity_rx #(.ODD_PARITY(1'b0)) u_even (
        .clk(clk), .rst(rst), .sin(sin), .bitEn(bitEn), .ack(ack),
        .dataOut(dout_e), .dataValid(dv_e), .parityErr(pe_e),
        .frameErr(fe_e), .overrun(ov_e), .busy(busy_e)
    );

    serial_parity_rx #(.ODD_PARITY(1'b1)) u_odd (
        .clk(clk), .rst(rst), .sin(sin), .bitEn(bitEn), .ack(ack),
        .dataOut(dout_o), .dataValid(dv_o), .parityErr(pe_o),
        .frameErr(fe_o), .overrun(ov_o), .busy(busy_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_data = 8'h00; m_valid = 1'b0; m_perr_even = 1'b0;
        m_perr_odd = 1'b0; m_ovr = 1'b0;
    endtask

    task automatic model_complete(input logic [7:0] d, input logic p, input logic ack_now);
        logic ones_odd;
        ones_odd = 1'b0;
        for (int i = 0; i < 8; i++) ones_odd = ones_odd ^ d[i];
        ones_odd = ones_odd ^ p;
        if (m_valid && !ack_now) m_ovr = 1'b1;
        if (m_valid && ack_now)  m_ovr = 1'b0;
        m_data = d; m_valid = 1'b1;
        m_perr_even = ones_odd; m_perr_odd = ~ones_odd;
    endtask

    task automatic model_ack();
        if (m_valid) begin m_valid = 1'b0; m_ovr = 1'b0; end
    endtask

    // One sampled bit; non-strobed cycles carry random junk on sin.
    task automatic send_bit(input logic b, input int gap, input logic ack_s);
        bitEn = 1'b0;
        for (int i = 1; i < gap; i++) begin
            sin = 1'($urandom_range(0, 1));
            tick();
        end
        sin = b; bitEn = 1'b1; ack = ack_s;
        tick();
        bitEn = 1'b0; ack = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic stop,
                              input int gap, input logic ack_on_stop);
        send_bit(1'b0, gap, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i], gap, 1'b0);
        send_bit(p, gap, 1'b0);
        send_bit(stop, gap, ack_on_stop);
    endtask

    task automatic do_ack();
        ack = 1'b1; tick(); ack = 1'b0;
        model_ack();
    endtask

    task automatic test_reset();
        rst = 1'b1; sin = 1'b0; bitEn = 1'b1; ack = 1'b1;
        tick(); tick();
        rst = 1'b0; sin = 1'b1; bitEn = 1'b0; ack = 1'b0;
        model_reset();
        checks++;
        if ({dout_e, dv_e, pe_e, fe_e, ov_e, busy_e} !== 13'h0) begin
            errors++;
            $display("FAIL reset_even got %h/%b%b%b%b%b want 00/00000", dout_e, dv_e, pe_e, fe_e, ov_e, busy_e);
        end
        checks++;
        if ({dout_o, dv_o, pe_o, fe_o, ov_o, busy_o} !== 13'h0) begin
            errors++;
            $display("FAIL reset_odd got %h/%b%b%b%b%b want 00/00000", dout_o, dv_o, pe_o, fe_o, ov_o, busy_o);
        end
    endtask

    task automatic test_basic_a5();
        send_frame(8'hA5, 1'b0, 1'b1, 3, 1'b0);
        model_complete(8'hA5, 1'b0, 1'b0);
        checks++;
        if (dout_e !== 8'hA5) begin errors++; $display("FAIL a5_data got %h want a5", dout_e); end
        checks++;
        if (pe_e !== 1'b0) begin errors++; $display("FAIL a5_perr_even got %b want 0", pe_e); end
        checks++;
        if (dv_e !== 1'b1) begin errors++; $display("FAIL a5_valid got %b want 1", dv_e); end
        checks++;
        if (busy_e !== 1'b0) begin errors++; $display("FAIL a5_busy got %b want 0", busy_e); end
        checks++;
        if (pe_o !== 1'b1) begin errors++; $display("FAIL a5_perr_odd got %b want 1", pe_o); end
        do_ack();
        checks++;
        if (dv_e !== 1'b0) begin errors++; $display("FAIL a5_ack_valid got %b want 0", dv_e); end
    endtask

    task automatic test_parity_01();
        send_frame(8'h01, 1'b0, 1'b1, 1, 1'b0);
        model_complete(8'h01, 1'b0, 1'b0);
        checks++;
        if (pe_e !== 1'b1) begin errors++; $display("FAIL p01_even got %b want 1", pe_e); end
        checks++;
        if (pe_o !== 1'b0) begin errors++; $display("FAIL p01_odd got %b want 0", pe_o); end
        checks++;
        if (dout_o !== 8'h01 || dv_o !== 1'b1) begin
            errors++; $display("FAIL p01_odd_data got %h/%b want 01/1", dout_o, dv_o);
        end
        do_ack();
    endtask

    task automatic test_break();
        int pulses;
        send_frame(8'h3C, 1'b0, 1'b0, 2, 1'b0);
        checks++;
        if (fe_e !== 1'b1) begin errors++; $display("FAIL brk_ferr got %b want 1", fe_e); end
        checks++;
        if (dv_e !== 1'b0 || dout_e !== m_data) begin
            errors++; $display("FAIL brk_hold got %h/%b want %h/0", dout_e, dv_e, m_data);
        end
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            send_bit(1'b0, 1, 1'b0);
            if (fe_e) pulses++;
            checks++;
            if (busy_e !== 1'b1 || dv_e !== 1'b0) begin
                errors++; $display("FAIL brk_wait%0d busy/valid got %b/%b want 1/0", i, busy_e, dv_e);
            end
        end
        checks++;
        if (pulses != 0) begin errors++; $display("FAIL brk_pulse extra pulses got %0d want 0", pulses); end
        send_bit(1'b1, 1, 1'b0);
        checks++;
        if (busy_e !== 1'b0) begin errors++; $display("FAIL brk_release busy got %b want 0", busy_e); end
        send_frame(8'h7E, 1'b0, 1'b1, 2, 1'b0);
        model_complete(8'h7E, 1'b0, 1'b0);
        checks++;
        if (dout_e !== 8'h7E || dv_e !== 1'b1) begin
            errors++; $display("FAIL brk_7e got %h/%b want 7e/1", dout_e, dv_e);
        end
        do_ack();
    endtask

    task automatic test_overrun();
        send_frame(8'h3C, 1'b0, 1'b1, 1, 1'b0);
        model_complete(8'h3C, 1'b0, 1'b0);
        send_frame(8'hC3, 1'b0, 1'b1, 2, 1'b0);
        model_complete(8'hC3, 1'b0, 1'b0);
        checks++;
        if (dout_e !== 8'hC3 || ov_e !== 1'b1) begin
            errors++; $display("FAIL ovr_set got %h/%b want c3/1", dout_e, ov_e);
        end
        do_ack();
        checks++;
        if (dv_e !== 1'b0 || ov_e !== 1'b0) begin
            errors++; $display("FAIL ovr_ack got %b/%b want 0/0", dv_e, ov_e);
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] d;
        send_frame(8'h11, 1'b0, 1'b1, 1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b1, 1, 1'b0);
        d = 8'hF0;
        send_bit(1'b0, 1, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i], 1, 1'b0);
        rst = 1'b1; bitEn = 1'b1; ack = 1'b1; sin = 1'b0;
        tick();
        rst = 1'b0; bitEn = 1'b0; ack = 1'b0; sin = 1'b1;
        model_reset();
        checks++;
        if ({dout_e, dv_e, pe_e, fe_e, ov_e, busy_e} !== 13'h0) begin
            errors++;
            $display("FAIL rstmid got %h/%b%b%b%b%b want 00/00000", dout_e, dv_e, pe_e, fe_e, ov_e, busy_e);
        end
        send_frame(8'h5A, 1'b0, 1'b1, 2, 1'b0);
        model_complete(8'h5A, 1'b0, 1'b0);
        checks++;
        if (dout_e !== 8'h5A || pe_e !== 1'b0 || ov_e !== 1'b0 || dv_e !== 1'b1) begin
            errors++; $display("FAIL rstmid_5a got %h/%b/%b/%b want 5a/0/0/1", dout_e, pe_e, ov_e, dv_e);
        end
    endtask

    task automatic test_ack_same_cycle();
        send_frame(8'h44, 1'b0, 1'b1, 1, 1'b0);
        model_complete(8'h44, 1'b0, 1'b0);
        send_frame(8'h99, 1'b0, 1'b1, 2, 1'b1);
        model_complete(8'h99, 1'b0, 1'b1);
        checks++;
        if (dv_e !== 1'b1 || dout_e !== 8'h99 || ov_e !== 1'b0) begin
            errors++; $display("FAIL ackcomp got %b/%h/%b want 1/99/0", dv_e, dout_e, ov_e);
        end
        do_ack();
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic       p, stop, a;
        int         gap;
        for (int n = 0; n < 40; n++) begin
            d    = 8'($urandom_range(0, 255));
            p    = 1'($urandom_range(0, 1));
            stop = ($urandom_range(0, 5) != 0);
            a    = 1'($urandom_range(0, 1));
            gap  = $urandom_range(1, 4);
            if ($urandom_range(0, 2) == 0) do_ack();
            send_frame(d, p, stop, gap, a);
            if (stop) model_complete(d, p, a);
            else if (a) model_ack();
            checks++;
            if ({dout_e, dv_e, pe_e, ov_e, fe_e, busy_e} !==
                {m_data, m_valid, m_perr_even, m_ovr, ~stop, ~stop}) begin
                errors++;
                $display("FAIL rand%0d_even got %h/%b%b%b%b%b want %h/%b%b%b%b%b", n,
                         dout_e, dv_e, pe_e, ov_e, fe_e, busy_e,
                         m_data, m_valid, m_perr_even, m_ovr, ~stop, ~stop);
            end
            checks++;
            if ({dout_o, dv_o, pe_o, ov_o} !== {m_data, m_valid, m_perr_odd, m_ovr}) begin
                errors++;
                $display("FAIL rand%0d_odd got %h/%b%b%b want %h/%b%b%b", n,
                         dout_o, dv_o, pe_o, ov_o, m_data, m_valid, m_perr_odd, m_ovr);
            end
            if (!stop) send_bit(1'b1, 1, 1'b0);
        end
    endtask

    initial begin
        rst = 1'b1; sin = 1'b1; bitEn = 1'b0; ack = 1'b0;
        model_reset();
        test_reset();
        test_basic_a5();
        test_parity_01();
        test_break();
        test_overrun();
        test_reset_midframe();
        test_ack_same_cycle();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_serial_parity_rx

// File: doc/serial_parity_rx.md
SERIAL_PARITY_RX -- requirements
Module: serial_parity_rx

Interface
REQ-001 SHALL have parameter ODD_PARITY, default 0; 0 selects even parity checking, 1 selects odd.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port sin, input, 1 bit: serial line; idle high.
REQ-005 SHALL have port bitEn, input, 1 bit: bit strobe; sin is sampled only on edges where bitEn=1.
REQ-006 SHALL have port ack, input, 1 bit: consumer acknowledges the held byte.
REQ-007 SHALL have port dataOut, output, 8 bits: last received byte.
REQ-008 SHALL have port dataValid, output, 1 bit: level, high while an unacknowledged byte is held.
REQ-009 SHALL have port parityErr, output, 1 bit: parity status of the held byte, qualified by dataValid.
REQ-010 SHALL have port frameErr, output, 1 bit: one-cycle pulse on a bad stop bit.
REQ-011 SHALL have port overrun, output, 1 bit: sticky flag; an unacknowledged byte was overwritten.
REQ-012 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-013 The frame format SHALL be: start bit 0, then data bits d0..d7 LSB first, then one parity bit, then stop bit 1; this is 11 sampled bits.
REQ-014 The FSM SHALL have states IDLE, DATA, PARITY, STOP and WAIT_HIGH; all transitions occur only on edges with bitEn=1.
REQ-015 IDLE SHALL go to DATA when sin=0; when sin=1 it SHALL stay in IDLE.
REQ-016 DATA SHALL shift sin into bit index cnt (3-bit counter, cleared on entry); after cnt=7 it SHALL go to PARITY.
REQ-017 PARITY SHALL capture the parity bit and go to STOP.
REQ-018 STOP with sin=1 SHALL complete the frame and go to IDLE.
REQ-019 STOP with sin=0 SHALL pulse frameErr for exactly one cycle, discard the byte, leave dataOut/dataValid/parityErr unchanged, and go to WAIT_HIGH.
REQ-020 WAIT_HIGH SHALL go to IDLE on the first sampled sin=1; a held-low line (break) SHALL never start a frame.
REQ-021 parityErr for a completed frame SHALL be (XOR of d0..d7 XOR parity bit) XOR ODD_PARITY.
REQ-022 On completion, dataOut, parityErr and dataValid=1 SHALL be visible on the cycle after the edge that samples the stop bit (latency 1 clk).
REQ-023 ack=1 while dataValid=1 SHALL clear dataValid and overrun on the next edge; ack while dataValid=0 SHALL have no effect.
REQ-024 A completion while dataValid=1 and ack=0 SHALL overwrite dataOut and parityErr, keep dataValid=1, and set overrun.
REQ-025 A completion in the same cycle as ack=1 SHALL load the new byte, keep dataValid=1, clear overrun, and not set overrun.
REQ-026 Cycles with bitEn=0 SHALL hold all state and counters unchanged, regardless of sin.
REQ-027 busy SHALL be combinationally derived from state; all other outputs SHALL be registered.

Reset
REQ-028 rst=1 SHALL force IDLE, cnt=0, shift register=0, dataOut=8'h00, dataValid=0, parityErr=0, frameErr=0, overrun=0 and busy=0 on the next edge.
REQ-029 rst SHALL take priority over bitEn, ack and any frame in progress; a partial frame SHALL be discarded.

Structure
REQ-030 State encodings, FRAME_BITS=11 and DATA_BITS=8 SHALL live in shared package parity_rx_pkg.
REQ-031 Parity SHALL be computed by one sub-module, parity_calc8 (8-bit data plus parity bit in, 1-bit even/odd mismatch out, purely combinational).

Verification
REQ-032 The bench SHALL send 0xA5 with parity bit 0 in even mode, with bitEn every 3rd clk; it SHALL check dataOut=0xA5, parityErr=0, dataValid=1 one clk after the stop sample, and busy low after.
REQ-033 The bench SHALL send 0x01 with parity bit 0 in even mode, then repeat with ODD_PARITY=1; it SHALL check parityErr=1 in even mode and parityErr=0 in odd mode.
REQ-034 The bench SHALL send 0x3C with stop bit 0, then hold sin=0 for 5 bitEn; it SHALL check a single frameErr pulse, dataValid=0, and no new frame; after sin=1 followed by a frame of 0x7E, it SHALL check dataOut=0x7E.
REQ-035 The bench SHALL send 0x3C then 0xC3 without ack, then pulse ack; it SHALL check dataOut=0xC3 and overrun=1, then dataValid=0 and overrun=0 after ack.
REQ-036 The bench SHALL assert rst after d3 of a frame, then send 0x5A; it SHALL check all outputs at reset values immediately after rst, then dataOut=0x5A, parityErr=0 and overrun=0.
REQ-037 The bench SHALL assert ack in the same cycle a frame of 0x99 completes; it SHALL check dataValid stays 1, dataOut=0x99 and overrun=0.
